// File: rtl/pcpu_pkg.sv
// pcpu_pkg: opcode values, FSM state encoding and instruction field extraction
// shared by the pcpu_core top and its register file.
package pcpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    // Extract 'width' bits starting at bit 'lsb'; callers truncate to the field width.
    function automatic logic [31:0] get_field(input logic [31:0] instr, input int lsb, input int width);
        return (instr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/pcpu_regfile.sv
// pcpu_regfile: 2**REG_ADDR_W x DATA_W registers, two async read ports,
// one synchronous write port, cleared by the core's async active-low reset.
module pcpu_regfile
    import pcpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0]     ra_data,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0]     rb_data,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata
);

    localparam int NREGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];

    // Next register contents: single write port.
    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    // Register storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/pcpu_core.sv
// pcpu_core: parametrised multi-cycle CPU, FETCH -> DECODE -> EXEC -> WB.
// Optional multiplier for opcode A is enabled by defining PCPU_MUL_EN; without it
// opcode A is a NOP and no multiplier exists.
module pcpu_core
    import pcpu_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int REG_ADDR_W = 4,
    parameter  int PC_W       = 8,
    localparam int INSTR_W    = 4 + 3 * REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]    imem_rdata,
    input  logic                  imem_valid,
    output logic [INSTR_W-1:0]    ir,
    output logic [PC_W-1:0]       pc,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0]     write_data,
    output logic                  write_en,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  halted
);

    state_e                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [INSTR_W-1:0]    ir_q, ir_d;
    logic [DATA_W-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic                  z_q, z_d, c_q, c_d;
    logic                  req_q, req_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    // Decoded fields of the instruction register.
    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rd, rs, rt;
    logic [DATA_W-1:0]     imm_data;
    logic [PC_W-1:0]       imm_pc;

    assign op       = 4'(get_field(32'(ir_q), INSTR_W - 4, 4));
    assign rd       = REG_ADDR_W'(get_field(32'(ir_q), 2 * REG_ADDR_W, REG_ADDR_W));
    assign rs       = REG_ADDR_W'(get_field(32'(ir_q), REG_ADDR_W, REG_ADDR_W));
    assign rt       = REG_ADDR_W'(get_field(32'(ir_q), 0, REG_ADDR_W));
    assign imm_data = DATA_W'(get_field(32'(ir_q), 0, 2 * REG_ADDR_W));
    assign imm_pc   = PC_W'(get_field(32'(ir_q), 0, 2 * REG_ADDR_W));

    // BEQZ tests R[rd], so port A reads rd for it and rs otherwise.
    logic [REG_ADDR_W-1:0] ra_addr;
    logic [DATA_W-1:0]     ra_data, rb_data;

    assign ra_addr = (op == OP_BEQZ) ? rd : rs;

    pcpu_regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (ra_addr),
        .ra_data (ra_data),
        .rb_addr (rt),
        .rb_data (rb_data),
        .we      (wen_q),
        .waddr   (waddr_q),
        .wdata   (wdata_q)
    );

    // ALU and next-pc for the instruction held in ir, using latched operands.
    logic [DATA_W-1:0] alu_res;
    logic              alu_wr, alu_upd_z, alu_c, alu_halt;
    logic [PC_W-1:0]   alu_pc;
    logic [DATA_W:0]   alu_sum, alu_diff;
`ifdef PCPU_MUL_EN
    logic [2*DATA_W-1:0] alu_prod;
`endif

    always_comb begin
        alu_res   = '0;
        alu_wr    = 1'b0;
        alu_upd_z = 1'b0;
        alu_c     = c_q;
        alu_halt  = 1'b0;
        alu_pc    = pc_q + PC_W'(1);
        alu_sum   = {1'b0, opa_q} + {1'b0, opb_q};
        alu_diff  = {1'b0, opa_q} - {1'b0, opb_q};
`ifdef PCPU_MUL_EN
        alu_prod  = opa_q * opb_q;
`endif
        case (op)
            OP_ADD:  begin alu_res = alu_sum[DATA_W-1:0];  alu_c = alu_sum[DATA_W];  alu_wr = 1'b1; alu_upd_z = 1'b1; end
            OP_SUB:  begin alu_res = alu_diff[DATA_W-1:0]; alu_c = alu_diff[DATA_W]; alu_wr = 1'b1; alu_upd_z = 1'b1; end
            OP_AND:  begin alu_res = opa_q & opb_q; alu_wr = 1'b1; alu_upd_z = 1'b1; end
            OP_OR:   begin alu_res = opa_q | opb_q; alu_wr = 1'b1; alu_upd_z = 1'b1; end
            OP_XOR:  begin alu_res = opa_q ^ opb_q; alu_wr = 1'b1; alu_upd_z = 1'b1; end
            OP_LDI:  begin alu_res = imm_data; alu_wr = 1'b1; end
            OP_MOV:  begin alu_res = opa_q;    alu_wr = 1'b1; end
            OP_BEQZ: if (opa_q == '0) alu_pc = imm_pc;
            OP_JMP:  alu_pc = imm_pc;
`ifdef PCPU_MUL_EN
            OP_MUL:  begin
                alu_res   = alu_prod[DATA_W-1:0];
                alu_c     = |alu_prod[2*DATA_W-1:DATA_W];
                alu_wr    = 1'b1;
                alu_upd_z = 1'b1;
            end
`endif
            OP_HALT: begin alu_halt = 1'b1; alu_pc = pc_q; end
            default: ;
        endcase
    end

    // Sequencer: next state, fetch handshake, operand latch, commit and write strobe.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        z_d     = z_q;
        c_d     = c_q;
        req_d   = req_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_FETCH: begin
                // req rises one cycle after reset; WB pre-raises it for later fetches.
                req_d = 1'b1;
                if (req_q && imem_valid) begin
                    ir_d    = imem_rdata;
                    req_d   = 1'b0;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                opa_d   = ra_data;
                opb_d   = rb_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (alu_halt) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = alu_pc;
                    c_d  = alu_c;
                    if (alu_upd_z) z_d = (alu_res == '0);
                    if (alu_wr) begin
                        wen_d   = 1'b1;
                        waddr_d = rd;
                        wdata_d = alu_res;
                    end
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                req_d   = 1'b1;
                state_d = ST_FETCH;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_HALT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            req_q   <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            z_q     <= z_d;
            c_q     <= c_d;
            req_q   <= req_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign write_addr = waddr_q;
    assign write_data = wdata_q;
    assign write_en   = wen_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_pcpu_core.sv
// tb_pcpu_core: program-driven bench for pcpu_core with an instruction-level
// reference model feeding a write-back scoreboard.
module tb_pcpu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic [3:0]  write_addr;
    logic [7:0]  write_data;
    logic        write_en, flag_z, flag_c, halted;

    pcpu_core dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .ir         (ir),
        .pc         (pc),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_total++;
        $display("FAIL %s", nm);
    endtask

    // ---------------- program memory and reference model ----------------
    logic [15:0] prog [256];

    int  m_regs [16];
    int  m_pc;
    bit  m_z, m_c, m_halted;

    typedef struct { int addr; int data; bit z; bit c; } exp_t;
    exp_t expq [$];
    exp_t mon_e;

    function automatic logic [15:0] ri(input int op, input int rd, input int rs, input int rt);
        return {4'(op), 4'(rd), 4'(rs), 4'(rt)};
    endfunction

    function automatic logic [15:0] fi(input int op, input int rd, input int imm);
        return {4'(op), 4'(rd), 8'(imm)};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_pc = 0; m_z = 0; m_c = 0; m_halted = 0;
    endtask

    // Executes one instruction architecturally and queues its expected write-back.
    task automatic model_step(input logic [15:0] ins);
        int op, rd, a, b, imm, r;
        bit w;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:8]);
        a   = m_regs[int'(ins[7:4])];
        b   = m_regs[int'(ins[3:0])];
        imm = int'(ins[7:0]);
        r = 0; w = 0;
        case (op)
            1: begin r = a + b; m_c = (r > 255); r = r % 256; m_z = (r == 0); w = 1; end
            2: begin m_c = (a < b); r = (a - b + 256) % 256; m_z = (r == 0); w = 1; end
            3: begin r = a & b; m_z = (r == 0); w = 1; end
            4: begin r = a | b; m_z = (r == 0); w = 1; end
            5: begin r = a ^ b; m_z = (r == 0); w = 1; end
            6: begin r = imm; w = 1; end
            7: begin r = a; w = 1; end
`ifdef PCPU_MUL_EN
            10: begin r = a * b; m_c = ((r / 256) != 0); r = r % 256; m_z = (r == 0); w = 1; end
`endif
            default: ;
        endcase
        if (op == 15) m_halted = 1;
        else if (op == 9) m_pc = imm;
        else if (op == 8 && m_regs[rd] == 0) m_pc = imm;
        else m_pc = (m_pc + 1) % 256;
        if (w) begin
            m_regs[rd] = r;
            expq.push_back('{addr: rd, data: r, z: m_z, c: m_c});
        end
    endtask

    // ---------------- instruction memory responder ----------------
    bit run_en = 0, spur_en = 0;
    int wait_min = 0, wait_max = 0, cur_wait = 0, wcnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            imem_valid = 1'b0;
            if (run_en) begin
                if (imem_req === 1'b1) begin
                    if (wcnt < cur_wait) begin
                        wcnt++;
                    end else begin
                        if (m_halted) fail("fetch_after_halt");
                        chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
                        imem_rdata = prog[imem_addr];
                        imem_valid = 1'b1;
                        model_step(prog[m_pc]);
                        wcnt = 0;
                        cur_wait = int'($urandom_range(wait_max, wait_min));
                    end
                end else if (spur_en && $urandom_range(1, 0) == 1) begin
                    // Junk with req low must be ignored.
                    imem_valid = 1'b1;
                    imem_rdata = 16'($urandom);
                end
            end
        end
    end

    // ---------------- write-back monitor ----------------
    int last_wr = 0, last_gap = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (write_en === 1'b1) begin
                last_gap = cyc - last_wr;
                last_wr  = cyc;
                if (expq.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    mon_e = expq.pop_front();
                    chk("wb_addr", 32'(write_addr), 32'(mon_e.addr));
                    chk("wb_data", 32'(write_data), 32'(mon_e.data));
                    chk("wb_flag_z", 32'(flag_z), 32'(mon_e.z));
                    chk("wb_flag_c", 32'(flag_c), 32'(mon_e.c));
                end
            end
        end
    end

    // ---------------- sequencing ----------------
    task automatic do_reset();
        @(negedge clk);
        run_en = 0;
        reset  = 1'b0;
        expq.delete();
        #1;
        chk("reset_ir_pc_wdata", {ir, pc, write_data}, 32'h0);
        chk("reset_waddr_ctl", {write_addr, write_en, flag_z, flag_c, imem_req, halted}, 32'h0);
        model_reset();
        wcnt = 0;
        cur_wait = int'($urandom_range(wait_max, wait_min));
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic finish_prog(input string name, input int exp_gap);
        int  i;
        bit  bad;
        i = 0;
        while (!(m_halted && halted === 1'b1) && i < 6000) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_halted"}, 32'(halted), 32'h1);
        @(negedge clk);
        chk({name, "_pc"}, 32'(pc), 32'(m_pc));
        chk({name, "_flags"}, {30'h0, flag_z, flag_c}, {30'h0, m_z, m_c});
        chk({name, "_pending"}, 32'(expq.size()), 32'h0);
        if (exp_gap > 0) chk({name, "_gap"}, 32'(last_gap), 32'(exp_gap));
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || write_en !== 1'b0 || halted !== 1'b1) bad = 1;
        end
        chk({name, "_halt_quiet"}, 32'(bad), 32'h0);
        run_en = 0;
    endtask

    task automatic run_prog(input string name, input int wmin, input int wmax, input bit spur,
                            input int exp_gap);
        wait_min = wmin;
        wait_max = wmax;
        spur_en  = spur;
        do_reset();
        run_en = 1;
        finish_prog(name, exp_gap);
    endtask

    task automatic gen_random(input int n);
        int op, tgt;
        clear_prog();
        for (int i = 0; i < n; i++) begin
            op = int'($urandom_range(14, 0));
            if ($urandom_range(2, 0) == 0) op = 6;
            if (op == 8 || op == 9) begin
                tgt = i + 1 + int'($urandom_range(3, 0));
                if (tgt > n) tgt = n;
                prog[i] = fi(op, int'($urandom_range(15, 0)), tgt);
            end else if (op == 6) begin
                prog[i] = fi(op, int'($urandom_range(15, 0)), int'($urandom_range(255, 0)));
            end else begin
                prog[i] = ri(op, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                             int'($urandom_range(15, 0)));
            end
        end
    endtask

    initial begin
        int i;

        // Basic add, zero-wait: write strobes 4 cycles apart.
        clear_prog();
        prog[0] = fi(6, 1, 8'h05); prog[1] = fi(6, 2, 8'h03); prog[2] = ri(1, 3, 1, 2);
        run_prog("add", 0, 0, 0, 4);

        // Same program with three wait states per fetch: 7 cycles per instruction.
        run_prog("wait3", 3, 3, 0, 7);

        // Carry and borrow.
        clear_prog();
        prog[0] = fi(6, 1, 8'hFF); prog[1] = fi(6, 2, 8'h01);
        prog[2] = ri(1, 3, 1, 2);  prog[3] = ri(2, 4, 2, 1);
        run_prog("carry", 0, 0, 0, 4);

        // Branch taken/not taken, jump to 0xFF and pc wrap to 0.
        clear_prog();
        prog[0]   = fi(8, 5, 8'h20);
        prog[32]  = fi(6, 5, 8'h01);
        prog[33]  = fi(8, 5, 8'h40);
        prog[34]  = fi(9, 0, 8'hFF);
        prog[255] = 16'h0000;
        run_prog("branch", 0, 0, 0, 0);

        // Optional multiply (NOP when the feature is compiled out).
        clear_prog();
        prog[0] = fi(6, 1, 8'h10); prog[1] = fi(6, 2, 8'h11); prog[2] = ri(10, 3, 1, 2);
        run_prog("mul", 0, 0, 0, 0);

        // Same-register forms use pre-write values; AND/LDI keep C.
        clear_prog();
        prog[0] = fi(6, 1, 8'h83); prog[1] = ri(1, 1, 1, 1);
        prog[2] = ri(3, 1, 1, 1);  prog[3] = ri(2, 1, 1, 1); prog[4] = fi(6, 7, 8'h00);
        run_prog("samereg", 0, 1, 1, 0);

        // Immediate HALT.
        clear_prog();
        run_prog("halt", 0, 0, 0, 0);

        // Reset asserted during EXEC of the ADD aborts it; restart proves registers cleared.
        clear_prog();
        prog[0] = fi(6, 1, 8'h05); prog[1] = fi(6, 2, 8'h03); prog[2] = ri(1, 3, 1, 2);
        wait_min = 0; wait_max = 0; spur_en = 0;
        do_reset();
        run_en = 1;
        i = 0;
        while (ir !== prog[2] && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("abort_reached_add", 32'(ir), 32'(prog[2]));
        prog[0] = ri(1, 3, 1, 2);
        prog[1] = 16'hF000;
        prog[2] = 16'hF000;
        do_reset();
        run_en = 1;
        finish_prog("abort", 0);

        // Random programs with forward-only branches, random wait states and junk valids.
        for (int k = 0; k < 8; k++) begin
            gen_random(40);
            run_prog("rand", 0, 2, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
